// File: rtl/iter_comp_pkg.sv
// Shared definitions for the iterative magnitude comparator: FSM states,
// index-width helper and the configuration legality check.
package iter_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit cfg_ok(input int width, input int slice);
    return (slice > 0) && (width >= slice) && (width % slice == 0);
  endfunction

endpackage

// File: rtl/iter_comp_if.sv
// Request/result handshake bundle between a requester and iter_comp.
interface iter_comp_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             EQ;
  logic             GT;
  logic             LT;

  modport master (
    output in_valid, A, B, is_signed, out_ready,
    input  in_ready, out_valid, EQ, GT, LT
  );

  modport slave (
    input  in_valid, A, B, is_signed, out_ready,
    output in_ready, out_valid, EQ, GT, LT
  );
endinterface

// File: rtl/iter_comp_comp_slice.sv
// One-slice comparator: equality plus greater-than, with optional MSB
// inversion so the top slice of a two's-complement operand orders correctly.
module comp_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             msb_invert,
  output logic             eq,
  output logic             gt
);
  logic [SLICE-1:0] flip;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    flip            = '0;
    flip[SLICE-1]   = msb_invert;
  end

  assign eq = (a == b);
  assign gt = ((a ^ flip) > (b ^ flip));
endmodule

// File: rtl/iter_comp.sv
// Multi-cycle magnitude comparator, MSB slice first, one slice per clock.
// Optional build macro ITER_COMP_EARLY_EXIT_EN: stop at the first unequal slice.
module iter_comp
  import iter_comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic       clock,
  input logic       reset,
  iter_comp_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = clog2_min1(NSLICE);
  typedef logic [IDXW-1:0] idx_t;
  localparam idx_t TOP_IDX = idx_t'(NSLICE - 1);

  if (!cfg_ok(WIDTH, SLICE)) begin : g_cfg_err
    $error("iter_comp: WIDTH must be a positive multiple of SLICE");
  end

  state_t           state, state_d;
  idx_t             idx, idx_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic             eq_q, gt_q, eq_d, gt_d;
  logic             load;

  logic [SLICE-1:0] a_sl, b_sl;
  logic             sl_eq, sl_gt, msb_inv;

  assign a_sl    = a_q[int'(idx) * SLICE +: SLICE];
  assign b_sl    = b_q[int'(idx) * SLICE +: SLICE];
  assign msb_inv = signed_q && (idx == TOP_IDX);

  comp_slice #(.SLICE(SLICE)) u_slice (
    .a          (a_sl),
    .b          (b_sl),
    .msb_invert (msb_inv),
    .eq         (sl_eq),
    .gt         (sl_gt)
  );

`ifndef ITER_COMP_EARLY_EXIT_EN
  // Constant-time build: the first unequal slice is remembered and later
  // slices are scanned but ignored.
  logic decided, decided_d;
  logic dec_gt, dec_gt_d;
`endif

  always_comb begin
    state_d = state;
    idx_d   = idx;
    eq_d    = eq_q;
    gt_d    = gt_q;
    load    = 1'b0;
`ifndef ITER_COMP_EARLY_EXIT_EN
    decided_d = decided;
    dec_gt_d  = dec_gt;
`endif
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          idx_d   = TOP_IDX;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = SCAN;
`ifndef ITER_COMP_EARLY_EXIT_EN
          decided_d = 1'b0;
          dec_gt_d  = 1'b0;
`endif
        end
      end
      SCAN: begin
`ifdef ITER_COMP_EARLY_EXIT_EN
        if (!sl_eq) begin
          eq_d    = 1'b0;
          gt_d    = sl_gt;
          state_d = DONE;
        end else if (idx == '0) begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx - idx_t'(1);
        end
`else
        if (!decided && !sl_eq) begin
          decided_d = 1'b1;
          dec_gt_d  = sl_gt;
        end
        if (idx == '0) begin
          eq_d    = decided ? 1'b0 : sl_eq;
          gt_d    = decided ? dec_gt : sl_gt;
          state_d = DONE;
        end else begin
          idx_d = idx - idx_t'(1);
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // NOTE: the operand registers are reset along with the control state, so the
  // slice mux and comparator never propagate X after power-up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx      <= TOP_IDX;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      idx  <= idx_d;
      eq_q <= eq_d;
      gt_q <= gt_d;
      if (load) begin
        a_q      <= bus.A;
        b_q      <= bus.B;
        signed_q <= bus.is_signed;
      end
    end
  end

`ifndef ITER_COMP_EARLY_EXIT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      decided <= 1'b0;
      dec_gt  <= 1'b0;
    end else begin
      decided <= decided_d;
      dec_gt  <= dec_gt_d;
    end
  end
`endif

  // in_ready is masked by reset so it reads low throughout the reset pulse.
  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = (state == DONE);
  assign bus.EQ        = eq_q;
  assign bus.GT        = gt_q;
  assign bus.LT        = (state == DONE) && !eq_q && !gt_q;

endmodule

// File: tb/tb_iter_comp.sv
// Self-checking bench for iter_comp: directed vectors, backpressure, reset
// abort, back-to-back issue and random compares against an arithmetic model.
module tb_iter_comp;
  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  iter_comp_if #(.WIDTH(WIDTH)) bus ();

  iter_comp #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    bit          eq;
    bit          gt;
    bit          lt;
    int          lat_ee;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: integer comparison under the chosen mode; latency is the count
  // of slices from the top down to the highest differing bit.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                output bit eq, output bit gt, output bit lt, output int lat);
    longint sa, sb;
    logic [31:0] x;
    int p;
    if (s) begin sa = $signed(a); sb = $signed(b); end
    else   begin sa = a;          sb = b;          end
    eq = (sa == sb);
    gt = (sa > sb);
    lt = (sa < sb);
`ifdef ITER_COMP_EARLY_EXIT_EN
    x = a ^ b;
    p = -1;
    for (int i = 31; i >= 0; i--) if (x[i] && p < 0) p = i;
    lat = (p < 0) ? NSLICE : NSLICE - p / SLICE;
`else
    x   = '0;
    p   = 0;
    lat = NSLICE;
`endif
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit s,
                        output int lat, output logic eq, output logic gt, output logic lt,
                        output int acc_cyc);
    int w = 0;
    while (!bus.in_ready && w < 50) begin tick(); w++; end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.A = a; bus.B = b; bus.is_signed = s; bus.in_valid = 1'b1;
    tick();
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.is_signed = 1'($urandom_range(0, 1));
    lat = -1;
    for (int k = 1; k <= 3 * NSLICE; k++) begin
      tick();
      if (bus.out_valid) begin lat = k; break; end
      check("in_ready_busy", bus.in_ready, 0);
    end
    eq = bus.EQ; gt = bus.GT; lt = bus.LT;
  endtask

  task automatic handshake(output int hs_cyc);
    bus.out_ready = 1'b1;
    tick();
    hs_cyc = cyc;
    check("out_valid_after_hs", bus.out_valid, 0);
    check("in_ready_after_hs", bus.in_ready, 1);
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input bit s, input bit e_eq, input bit e_gt, input bit e_lt,
                         input int e_lat);
    int lat, acc, hs;
    logic eq, gt, lt;
    launch(a, b, s, lat, eq, gt, lt, acc);
    check({name, ".eq"}, eq, e_eq);
    check({name, ".gt"}, gt, e_gt);
    check({name, ".lt"}, lt, e_lt);
    check({name, ".lat"}, lat, e_lat);
    handshake(hs);
  endtask

  initial begin
    int lat, acc1, acc2, hs1, seen;
    logic eq, gt, lt;
    bit m_eq, m_gt, m_lt;
    int m_lat;
    logic [31:0] ra, rb;
    bit rs;

    vecs[0] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{32'h00000100, 32'h000000FF, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[6] = '{32'h00000005, 32'h00000003, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 4};
    vecs[8] = '{32'hFFFFFF80, 32'hFFFFFF7F, 1'b1, 1'b0, 1'b1, 1'b0, 4};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.is_signed = 1'b0; bus.out_ready = 1'b1;
    #2;
    check("rst.in_ready", bus.in_ready, 0);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.flags", {bus.EQ, bus.GT, bus.LT}, 3'b000);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_rel.in_ready", bus.in_ready, 1);
    check("rst_rel.out_valid", bus.out_valid, 0);

    for (int i = 0; i < 9; i++) begin
`ifdef ITER_COMP_EARLY_EXIT_EN
      run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
              vecs[i].eq, vecs[i].gt, vecs[i].lt, vecs[i].lat_ee);
`else
      run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
              vecs[i].eq, vecs[i].gt, vecs[i].lt, NSLICE);
`endif
    end

    // Backpressure: result held in DONE for five cycles, released on the sixth.
    bus.out_ready = 1'b0;
    launch(32'h80000000, 32'h7FFFFFFF, 1'b0, lat, eq, gt, lt, acc1);
    for (int i = 0; i < 5; i++) begin
      check("bp.out_valid", bus.out_valid, 1);
      check("bp.in_ready", bus.in_ready, 0);
      check("bp.flags", {bus.EQ, bus.GT, bus.LT}, 3'b010);
      tick();
    end
    check("bp.out_valid6", bus.out_valid, 1);
    handshake(hs1);
    check("bp.flags_cleared", {bus.EQ, bus.GT, bus.LT}, 3'b000);

    // Reset during the second SCAN cycle drops the compare.
    bus.A = 32'h00000001; bus.B = 32'h00000000; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("abort.in_ready", bus.in_ready, 0);
    check("abort.out_valid", bus.out_valid, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("abort.in_ready_rel", bus.in_ready, 1);
    seen = 0;
    for (int i = 0; i < NSLICE + 2; i++) begin
      if (bus.out_valid) seen = 1;
      tick();
    end
    check("abort.no_result", seen, 0);
    run_one("post_abort", 32'd5, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, NSLICE);

    // Back-to-back: second accept lands one edge after the first handshake.
    launch(32'h00000100, 32'h000000FF, 1'b0, lat, eq, gt, lt, acc1);
    check("b2b.first.gt", gt, 1);
    handshake(hs1);
    launch(32'hFFFFFFFF, 32'h00000001, 1'b1, lat, eq, gt, lt, acc2);
    check("b2b.second.lt", lt, 1);
    check("b2b.accept_gap", acc2 - hs1, 1);
    handshake(hs1);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
        2:       rb = $urandom;
        default: rb = {ra[31:16], 16'($urandom)};
      endcase
      model(ra, rb, rs, m_eq, m_gt, m_lt, m_lat);
      run_one("rand", ra, rb, rs, m_eq, m_gt, m_lt, m_lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
